// File: rtl/gpio_multi_port_if.sv
// gpio_multi_port_if: peripheral register bus between the core and gpio_multi_port
interface gpio_multi_port_if #(
  parameter int ADDRW = 11,
  parameter int XLEN = 32
);
  logic [ADDRW-1:0] addr;
  logic [XLEN-1:0] wrData;
  logic [XLEN-1:0] dataOut;
  logic wrEn;
  logic rdEn;
  logic outEn;
  modport master(output addr, wrData, wrEn, rdEn, input dataOut, outEn);
  modport slave(input addr, wrData, wrEn, rdEn, output dataOut, outEn);
endinterface

// File: rtl/gpio_multi_port.sv
// gpio_multi_port: PORT_COUNT GPIO ports with direction, output value, synchronised input and edge interrupts
module gpio_multi_port #(
  parameter int PORT_COUNT = 2,
  parameter int PORT_SIZE = 8,
  parameter int ADDRW = 11,
  parameter int XLEN = 32,
  parameter logic [ADDRW-1:0] BASE_ADDR = 11'h404
) (
  input  logic clk,
  input  logic rstB,
  gpio_multi_port_if.slave bus,
  output logic [PORT_COUNT*PORT_SIZE-1:0] ddr,
  output logic [PORT_COUNT*PORT_SIZE-1:0] pvl,
  input  logic [PORT_COUNT*PORT_SIZE-1:0] pin,
  output logic irq
);
  localparam int N = PORT_COUNT*PORT_SIZE;
  localparam int PW = ADDRW-3;
  logic [N-1:0] ifr, ier, edg, s1, s2, s3, set, clr;
  logic [1:0] warm;
  logic [ADDRW-1:0] off;
  logic [PW-1:0] port;
  logic [2:0] offs;
  logic hit, wr, rd;
  logic [PORT_SIZE-1:0] wd, rd_val;
  logic unused;
  assign unused = ^bus.wrData;
  assign off = bus.addr - BASE_ADDR;
  assign port = off[ADDRW-1:3];
  assign offs = off[2:0];
  assign hit = bus.addr >= BASE_ADDR && off < ADDRW'(8*PORT_COUNT);
  assign wr = bus.wrEn & hit;
  assign rd = bus.rdEn & hit;
  assign wd = bus.wrData[PORT_SIZE-1:0];
  // warm-up masks the edges created while the synchroniser fills after reset
  assign set = warm == 2'd3 ? ((s2 & ~s3 & edg) | (~s2 & s3 & ~edg)) : '0;
  assign irq = |(ifr & ier);
  always_comb begin
    rd_val = '0;
    clr = '0;
    for (int p = 0; p < PORT_COUNT; p++)
      if (port == PW'(p)) begin
        rd_val = offs == 3'd0 ? ddr[p*PORT_SIZE +: PORT_SIZE] :
                 offs == 3'd1 ? pvl[p*PORT_SIZE +: PORT_SIZE] :
                 offs == 3'd2 ? s2[p*PORT_SIZE +: PORT_SIZE] :
                 offs == 3'd3 ? ifr[p*PORT_SIZE +: PORT_SIZE] :
                 offs == 3'd4 ? ier[p*PORT_SIZE +: PORT_SIZE] :
                 offs == 3'd5 ? edg[p*PORT_SIZE +: PORT_SIZE] : '0;
        clr[p*PORT_SIZE +: PORT_SIZE] = wr && offs == 3'd3 ? wd : '0;
      end
  end
  always_ff @(posedge clk) begin
    if (!rstB) begin
      ddr <= '0;
      pvl <= '0;
      ifr <= '0;
      ier <= '0;
      edg <= '1;
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      warm <= '0;
      bus.dataOut <= '0;
      bus.outEn <= 1'b0;
    end else begin
      warm <= warm == 2'd3 ? warm : warm + 2'd1;
      s1 <= pin;
      s2 <= s1;
      s3 <= s2;
      ifr <= (ifr & ~clr) | set;
      bus.outEn <= rd;
      bus.dataOut <= rd ? XLEN'(rd_val) : '0;
      for (int p = 0; p < PORT_COUNT; p++)
        if (wr && port == PW'(p)) begin
          if (offs == 3'd0) ddr[p*PORT_SIZE +: PORT_SIZE] <= wd;
          if (offs == 3'd1) pvl[p*PORT_SIZE +: PORT_SIZE] <= wd;
          if (offs == 3'd4) ier[p*PORT_SIZE +: PORT_SIZE] <= wd;
          if (offs == 3'd5) edg[p*PORT_SIZE +: PORT_SIZE] <= wd;
        end
    end
  end
endmodule
